rv32i_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the RV32I execute stage. It sits beside ID/EX and watches the

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/rv32i_src_use.sv | 21 ++
 rtl/rv32i_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_rv32i_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, the canonical NOP and the hazard sequencer state type.
package rv32i_pkg;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_R     = 7'b0110011;
  localparam logic [6:0]  OPC_S     = 7'b0100011;
  localparam logic [6:0]  OPC_B     = 7'b1100011;
  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;
  localparam logic [6:0]  OPC_JALR  = 7'b1100111;

  localparam logic [31:0] RV32I_NOP = 32'h00000013;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;

endpackage

// File: rtl/rv32i_src_use.sv
// Decodes which source registers an RV32I instruction reads and extracts their indices.
module rv32i_src_use
  import rv32i_pkg::*;
(
  input  logic [31:0] iw,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opc;

  assign opc      = iw[6:0];
  assign rs1      = iw[19:15];
  assign rs2      = iw[24:20];
  // Upper-immediate and JAL formats reuse bits 19:15 as immediate, not as a register.
  assign uses_rs1 = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  assign uses_rs2 = (opc == OPC_R) || (opc == OPC_S) || (opc == OPC_B);

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Load-use stall and branch-redirect sequencer for the RV32I ID/EX boundary.
// Optional performance counters are built when RV32I_HAZARD_PERF_EN is defined.
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_iw_in,
  input  logic [31:0] ex_iw_in,
  input  logic        ex_wb_en_in,
  input  logic [4:0]  ex_wb_reg_in,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_bubble,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_val,
  output logic        busy
`ifdef RV32I_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_redirects
`endif
);

  localparam int unsigned MAX_CNT = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  hz_state_t  state_reg, state_next;
  cnt_t       cnt_reg, cnt_next, cnt_dec;
  logic       id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic       hazard;
  logic       unused_ex_iw;

  rv32i_src_use u_src_use (
    .iw       (id_iw_in),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .rs1      (id_rs1),
    .rs2      (id_rs2)
  );

  // Only the opcode of the EX word matters; destination comes from ex_wb_reg_in.
  assign unused_ex_iw = ^ex_iw_in[31:7];

  assign hazard = (ex_iw_in[6:0] == OPC_LOAD) && ex_wb_en_in && (ex_wb_reg_in != 5'd0) && id_valid &&
                  ((id_uses_rs1 && (id_rs1 == ex_wb_reg_in)) ||
                   (id_uses_rs2 && (id_rs2 == ex_wb_reg_in)));

  assign cnt_dec = (cnt_reg == cnt_t'(0)) ? cnt_t'(0) : cnt_reg - cnt_t'(1);
  assign busy    = (state_reg != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= cnt_t'(0);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    if_stall        = 1'b0;
    id_stall        = 1'b0;
    ex_bubble       = 1'b0;
    pc_redirect     = 1'b0;
    pc_redirect_val = 32'd0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          // A redirect squashes the decode instruction, so its hazard is moot.
          if (ex_redirect) begin
            pc_redirect     = 1'b1;
            pc_redirect_val = ex_target;
            ex_bubble       = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              cnt_next   = cnt_t'(FLUSH_CYCLES - 1);
            end
          end else if (hazard) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = STALL;
              cnt_next   = cnt_t'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
          cnt_next  = cnt_dec;
          if (cnt_dec == cnt_t'(0)) state_next = RUN;
        end
        FLUSH: begin
          ex_bubble = 1'b1;
          cnt_next  = cnt_dec;
          if (cnt_dec == cnt_t'(0)) state_next = RUN;
        end
        default: begin
          state_next = RUN;
          cnt_next   = cnt_t'(0);
        end
      endcase
    end
  end

`ifdef RV32I_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_redirects <= 32'd0;
    end else begin
      if (if_stall)              perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ex_bubble && !if_stall) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (pc_redirect)           perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Directed bench for rv32i_hazard_ctrl: default instance plus a LOAD_LAT=3 instance.
// Perf counter checks are compiled when RV32I_HAZARD_PERF_EN is defined.
module tb_rv32i_hazard_ctrl;

  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X5  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] ADD_X0  = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] ADD_RS2 = 32'h00538333; // add  x6,x7,x5
  localparam logic [31:0] ADD_ALU = 32'h002082B3; // add  x5,x1,x2
  localparam logic [31:0] ADD_IND = 32'h00838333; // add  x6,x7,x8
  localparam logic [31:0] SW_X5   = 32'h00512023; // sw   x5,0(x2)
  localparam logic [31:0] LUI_X5  = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] JAL_F5  = 32'h0002806F; // jal  x0 with bits 19:15 = 5
  localparam logic [31:0] BEQ     = 32'h00208063; // beq  x1,x2,0
  localparam logic [31:0] NOP     = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, reset3;
  logic        id_valid, ex_wb_en, ex_redirect;
  logic [31:0] id_iw, ex_iw, ex_target;
  logic [4:0]  ex_wb_reg;

  logic        a_if_stall, a_id_stall, a_ex_bubble, a_pc_redirect, a_busy;
  logic [31:0] a_pc_val;
  logic        b_if_stall, b_id_stall, b_ex_bubble, b_pc_redirect, b_busy;
  logic [31:0] b_pc_val;
`ifdef RV32I_HAZARD_PERF_EN
  logic [31:0] a_perf_stall, a_perf_flush, a_perf_redir;
  logic [31:0] b_perf_stall, b_perf_flush, b_perf_redir;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32i_hazard_ctrl u_dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_iw_in        (id_iw),
    .ex_iw_in        (ex_iw),
    .ex_wb_en_in     (ex_wb_en),
    .ex_wb_reg_in    (ex_wb_reg),
    .ex_redirect     (ex_redirect),
    .ex_target       (ex_target),
    .if_stall        (a_if_stall),
    .id_stall        (a_id_stall),
    .ex_bubble       (a_ex_bubble),
    .pc_redirect     (a_pc_redirect),
    .pc_redirect_val (a_pc_val),
    .busy            (a_busy)
`ifdef RV32I_HAZARD_PERF_EN
    ,
    .perf_stall_cnt  (a_perf_stall),
    .perf_flush_cnt  (a_perf_flush),
    .perf_redirects  (a_perf_redir)
`endif
  );

  rv32i_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2)) u_dut3 (
    .clk             (clk),
    .reset           (reset3),
    .id_valid        (id_valid),
    .id_iw_in        (id_iw),
    .ex_iw_in        (ex_iw),
    .ex_wb_en_in     (ex_wb_en),
    .ex_wb_reg_in    (ex_wb_reg),
    .ex_redirect     (ex_redirect),
    .ex_target       (ex_target),
    .if_stall        (b_if_stall),
    .id_stall        (b_id_stall),
    .ex_bubble       (b_ex_bubble),
    .pc_redirect     (b_pc_redirect),
    .pc_redirect_val (b_pc_val),
    .busy            (b_busy)
`ifdef RV32I_HAZARD_PERF_EN
    ,
    .perf_stall_cnt  (b_perf_stall),
    .perf_flush_cnt  (b_perf_flush),
    .perf_redirects  (b_perf_redir)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic is, input logic ids, input logic eb,
                       input logic pr, input logic [31:0] prv, input logic bz);
    chk({tag, "/if_stall"}, {31'd0, a_if_stall}, {31'd0, is});
    chk({tag, "/id_stall"}, {31'd0, a_id_stall}, {31'd0, ids});
    chk({tag, "/ex_bubble"}, {31'd0, a_ex_bubble}, {31'd0, eb});
    chk({tag, "/pc_redirect"}, {31'd0, a_pc_redirect}, {31'd0, pr});
    chk({tag, "/pc_redirect_val"}, a_pc_val, prv);
    chk({tag, "/busy"}, {31'd0, a_busy}, {31'd0, bz});
  endtask

  task automatic chk_b(input string tag, input logic is, input logic ids, input logic eb,
                       input logic pr, input logic [31:0] prv, input logic bz);
    chk({tag, "/if_stall"}, {31'd0, b_if_stall}, {31'd0, is});
    chk({tag, "/id_stall"}, {31'd0, b_id_stall}, {31'd0, ids});
    chk({tag, "/ex_bubble"}, {31'd0, b_ex_bubble}, {31'd0, eb});
    chk({tag, "/pc_redirect"}, {31'd0, b_pc_redirect}, {31'd0, pr});
    chk({tag, "/pc_redirect_val"}, b_pc_val, prv);
    chk({tag, "/busy"}, {31'd0, b_busy}, {31'd0, bz});
  endtask

  // Apply one cycle of inputs after the falling edge and let them settle.
  task automatic step(input logic idv, input logic [31:0] idw, input logic [31:0] exw,
                      input logic wbe, input logic [4:0] wbr, input logic rd,
                      input logic [31:0] tgt);
    @(negedge clk);
    id_valid    = idv;
    id_iw       = idw;
    ex_iw       = exw;
    ex_wb_en    = wbe;
    ex_wb_reg   = wbr;
    ex_redirect = rd;
    ex_target   = tgt;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    reset3 = 1'b1;
    id_valid = 1'b1;
    id_iw = ADD_X5;
    ex_iw = LW_X5;
    ex_wb_en = 1'b1;
    ex_wb_reg = 5'd5;
    ex_redirect = 1'b0;
    ex_target = 32'd0;

    // Reset with a live hazard on the inputs: everything held low.
    repeat (2) @(negedge clk);
    #1;
    chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("reset: outputs checked with hazard present");
    @(negedge clk);
    reset = 1'b0;

    // Load-use, LOAD_LAT=1: one stall cycle, FSM stays in RUN.
    step(1'b1, ADD_X5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_a("s1c1", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_X5, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_a("s1c2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("s1: lw x5 / add x6,x5,x2 stall sequence");

    // Taken branch, FLUSH_CYCLES=2.
    step(1'b1, ADD_IND, BEQ, 1'b0, 5'd0, 1'b1, 32'h0000_0100);
    chk_a("s3c1", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b1, ADD_IND, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_a("s3c2", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, ADD_IND, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_a("s3c3", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("s3: beq redirect to 0x100 and flush");

`ifdef RV32I_HAZARD_PERF_EN
    chk("perf_stall_cnt", a_perf_stall, 32'd1);
    chk("perf_flush_cnt", a_perf_flush, 32'd2);
    chk("perf_redirects", a_perf_redir, 32'd1);
    $display("perf: counters after s1+s3");
`endif

    // Redirect and hazard together; then hazard and redirect while flushing.
    step(1'b1, ADD_X5, LW_X5, 1'b1, 5'd5, 1'b1, 32'h0000_0200);
    chk_a("s4c1", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b1, 5'd5, 1'b1, 32'h0000_0300);
    chk_a("s4c2_flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, ADD_IND, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_a("s4c3", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("s4: redirect beats hazard; flush ignores hazard/redirect");

    // Cases that must not stall.
    step(1'b1, ADD_X0, LW_X0, 1'b1, 5'd0, 1'b0, 32'd0);
    chk_a("s2_x0", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, LUI_X5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_a("s2_lui", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, JAL_F5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_a("s2_jal", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, ADD_X5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_a("s2_idinv", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 5'd5, 1'b0, 32'd0);
    chk_a("s2_nowb", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_X5, ADD_ALU, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_a("s2_alu", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("s2: non-hazard patterns");

    // rs2-only hazards (store data, R-type second operand).
    step(1'b1, SW_X5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_a("rs2_sw", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_RS2, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_a("rs2_add", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_RS2, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_a("rs2_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("rs2: store and R-type rs2 hazards");

    // LOAD_LAT=3 instance: full three-cycle stall.
    @(negedge clk);
    reset3 = 1'b0;
    step(1'b1, ADD_X5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_b("l3c1", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_X5, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_b("l3c2", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, ADD_X5, NOP, 1'b0, 5'd0, 1'b1, 32'h0000_0400);
    chk_b("l3c3_noredir", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, ADD_X5, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_b("l3c4", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("l3: LOAD_LAT=3 stall length");

    // Reset mid-STALL takes effect without a clock edge.
    step(1'b1, ADD_X5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_b("r5c1", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_X5, NOP, 1'b0, 5'd0, 1'b0, 32'd0);
    chk_b("r5c2", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    #1;
    reset3 = 1'b1;
    #1;
    chk_b("r5_async", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    reset3 = 1'b0;
    #1;
    chk_b("r5_release", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b1, 5'd5, 1'b0, 32'd0);
    chk_b("r5_rerun", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    $display("r5: async reset aborts STALL");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
